mxalu_seq: RTL

//  Parametrised, multi-cycle unsigned ALU for MX datapaths wider than one byte. It

---
 rtl/mxalu_pkg.sv | 51 +++++
 rtl/mxalu_slice4.sv | 19 +
 rtl/mxalu_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/mxalu_pkg.sv
// mxalu_pkg: opcodes, 181 decode, flag bit positions and FSM states
package mxalu_pkg;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOTA  = 4'd5;
    localparam logic [3:0] OP_PASSA = 4'd6;
    localparam logic [3:0] OP_PASSB = 4'd7;
    localparam logic [3:0] OP_INC   = 4'd8;
    localparam logic [3:0] OP_DEC   = 4'd9;
    localparam logic [3:0] OP_ADC   = 4'd10;
    localparam logic [3:0] OP_SBB   = 4'd11;
    localparam logic [3:0] OP_CMP   = 4'd12;
    localparam logic [3:0] OP_ZERO  = 4'd13;
    localparam logic [3:0] OP_ONES  = 4'd14;
    localparam logic [3:0] OP_NAND  = 4'd15;
    localparam int FZ = 0;
    localparam int FC = 1;
    localparam int FE = 2;
    localparam int FN = 3;
    localparam int FH = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       cn_n;
    } dec_t;
    // c is the persisted carry flag; ADC/SBB feed it in as active-low carry
    function automatic dec_t decode(input logic [3:0] op, input logic c);
        case (op)
            OP_ADD:   decode = {4'b1001, 1'b0, 1'b1};
            OP_SUB:   decode = {4'b0110, 1'b0, 1'b0};
            OP_AND:   decode = {4'b1011, 1'b1, 1'b1};
            OP_OR:    decode = {4'b1110, 1'b1, 1'b1};
            OP_XOR:   decode = {4'b0110, 1'b1, 1'b1};
            OP_NOTA:  decode = {4'b0000, 1'b1, 1'b1};
            OP_PASSA: decode = {4'b1111, 1'b1, 1'b1};
            OP_PASSB: decode = {4'b1010, 1'b1, 1'b1};
            OP_INC:   decode = {4'b0000, 1'b0, 1'b0};
            OP_DEC:   decode = {4'b1111, 1'b0, 1'b1};
            OP_ADC:   decode = {4'b1001, 1'b0, ~c};
            OP_SBB:   decode = {4'b0110, 1'b0, ~c};
            OP_CMP:   decode = {4'b0110, 1'b0, 1'b0};
            OP_ZERO:  decode = {4'b0011, 1'b1, 1'b1};
            OP_ONES:  decode = {4'b1100, 1'b1, 1'b1};
            default:  decode = {4'b0100, 1'b1, 1'b1};
        endcase
    endfunction
endpackage

// File: rtl/mxalu_slice4.sv
// mxalu_slice4: combinational 74181-style 4-bit slice, active-high data
module mxalu_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn_n,
    output logic [3:0] f,
    output logic       cn4_n
);
    logic [3:0] w_t1;
    logic [3:0] w_t2;
    logic [4:0] w_sum;
    assign w_t1  = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    assign w_t2  = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    assign w_sum = {1'b0, w_t1} + {1'b0, w_t2} + {4'b0, ~cn_n};
    assign f     = m ? ~(w_t1 ^ w_t2) : w_sum[3:0];
    assign cn4_n = m | ~w_sum[4];
endmodule

// File: rtl/mxalu_seq.sv
// mxalu_seq: multi-cycle ALU running one 181 slice per cycle, carry rippled through a register
module mxalu_seq
    import mxalu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] f,
    output logic [4:0]        flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int SLICE_W = 4;
    localparam int NSLICE  = DATA_W / SLICE_W;
    localparam int CNT_W   = NSLICE > 1 ? $clog2(NSLICE) : 1;
    state_t            r_state;
    dec_t              r_dec;
    dec_t              w_dec;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_res;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cy;
    logic              r_h;
    logic              r_cmp;
    logic              w_last;
    logic              w_h;
    logic              w_cn4_n;
    logic [SLICE_W-1:0] w_f;
    assign in_ready  = r_state == IDLE && !cs_n;
    assign busy      = r_state != IDLE;
    assign out_valid = r_state == DONE;
    assign w_dec     = decode(opcode, flags[FC]);
    assign w_last    = r_cnt == CNT_W'(NSLICE - 1);
    assign w_h       = r_cnt == '0 ? ~w_cn4_n : r_h;
    // full result including the slice being computed this cycle, for the flags
    always_comb begin
        w_res = r_acc;
        w_res[SLICE_W*r_cnt +: SLICE_W] = w_f;
    end
    mxalu_slice4 u_slice (
        .a     (r_a[SLICE_W*r_cnt +: SLICE_W]),
        .b     (r_b[SLICE_W*r_cnt +: SLICE_W]),
        .s     (r_dec.s),
        .m     (r_dec.m),
        .cn_n  (r_cy),
        .f     (w_f),
        .cn4_n (w_cn4_n)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_dec   <= '0;
            r_cy    <= 1'b1;
            r_h     <= 1'b0;
            r_cmp   <= 1'b0;
            f       <= '0;
            flags   <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid && in_ready) begin
                    r_a     <= a;
                    r_b     <= b;
                    r_dec   <= w_dec;
                    r_cy    <= w_dec.cn_n;
                    r_cmp   <= opcode == OP_CMP;
                    r_cnt   <= '0;
                    r_state <= RUN;
                end
                RUN: begin
                    r_acc[SLICE_W*r_cnt +: SLICE_W] <= w_f;
                    if (!r_cmp) f[SLICE_W*r_cnt +: SLICE_W] <= w_f;
                    r_cy  <= w_cn4_n;
                    r_h   <= w_h;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state   <= DONE;
                        flags[FZ] <= w_res == '0;
                        flags[FE] <= r_a == r_b;
                        flags[FN] <= w_res[DATA_W-1];
                        flags[FC] <= r_dec.m ? flags[FC] : ~w_cn4_n;
                        flags[FH] <= !r_dec.m && w_h;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
